sync_pattern_receiver: RTL and testbench

- Slave-side consumer of the n-high-in-m sync line driven by a master FONT5 board, or by a local synchroniser in master mode.
- Samples the line on each rising edge of the shared toggle_en strobe and checks each frame against the expected cnt_n/cnt_m pattern.
- Declares lock after consecutive good frames and reconstructs the master's frame phase counter.
- Outputs feed downstream trigger/timing logic and status registers.

---
 rtl/sync_pattern_receiver_pkg.sv | 14 +
 rtl/sync_pattern_receiver_edge.sv | 32 +++
 rtl/sync_pattern_receiver.sv | 209 ++++++++++++++++++++
 tb/tb_sync_pattern_receiver.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_pattern_receiver_pkg.sv
// Shared types and default widths for the sync pattern receiver.
package sync_pattern_receiver_pkg;

  // Receiver lock state.
  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } rx_state_t;

  localparam int DEF_CNT_W = 2;
  localparam int DEF_ERR_W = 8;

endpackage

// File: rtl/sync_pattern_receiver_edge.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
// The pulse is high for one clk, three clk edges after the raw input edge.
module sync_edge_detector (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;

  // Synchronise the raw input and register a one-clk pulse on its rising edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/sync_pattern_receiver.sv
// Slave-side receiver for the n-high-in-m sync line: measures each frame,
// acquires/keeps lock, reconstructs the master phase and counts bad frames.
//
// state    | meaning
// UNLOCKED | waiting for the first frame start; phase held at 0
// ACQUIRE  | counting consecutive good frames towards lock
// LOCKED   | locked; consecutive bad frames counted towards unlock
//
// A timeout restarts measurement with the counters at 0. A frame start seen
// while the counters are still 0 only begins a new measurement, so a frame
// already judged bad by timeout is not judged a second time.
module sync_pattern_receiver import sync_pattern_receiver_pkg::*; #(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int LOCK_FRAMES = 4,
  parameter int MISS_LIMIT  = 2,
  parameter int ERR_W       = DEF_ERR_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_toggle_en,
  input  logic             i_sync_in,
  input  logic [CNT_W-1:0] i_cnt_n,
  input  logic [CNT_W-1:0] i_cnt_m,
  output logic             o_locked,
  output logic             o_frame_start,
  output logic [CNT_W-1:0] o_phase,
  output logic [ERR_W-1:0] o_err_cnt
);

  localparam int CW1 = CNT_W + 1;
  localparam logic [CW1-1:0]   C1 = CW1'(1);
  localparam logic [CW1-1:0]   C2 = CW1'(2);
  localparam logic [CNT_W-1:0] P1 = CNT_W'(1);
  localparam logic [3:0]       G1 = 4'd1;
  localparam logic [ERR_W-1:0] E1 = ERR_W'(1);

  rx_state_t        r_state,  w_state_nx;
  logic [3:0]       r_good,   w_good_nx;
  logic [3:0]       r_miss,   w_miss_nx;
  logic [CW1-1:0]   r_hi,     w_hi_nx;
  logic [CW1-1:0]   r_per,    w_per_nx;
  logic [CNT_W-1:0] r_phase,  w_phase_nx;
  logic [CNT_W-1:0] r_exp_n,  w_exp_n_nx;
  logic [CNT_W-1:0] r_exp_m,  w_exp_m_nx;
  logic [ERR_W-1:0] r_err,    w_err_nx;
  logic             r_s_prev, w_s_prev_nx;
  logic             r_fs,     w_fs_nx;
  logic             r_sin_meta;
  logic             r_sin_sync;

  logic             w_tick;
  logic             w_s;
  logic             w_frame_edge;
  logic             w_eval;
  logic             w_good_frame;
  logic [CW1-1:0]   w_exp_n1;
  logic [CW1-1:0]   w_exp_m1;
  logic [CW1-1:0]   w_exp_m2;
  logic [CW1-1:0]   w_hi_inc;
  logic [CW1-1:0]   w_per_inc;
  logic [ERR_W-1:0] w_err_inc;

  sync_edge_detector u_toggle_edge (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_toggle_en),
    .o_rise  (w_tick)
  );

  // Two-flop synchroniser for the sync line level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sin_meta <= 1'b0;
      r_sin_sync <= 1'b0;
    end else begin
      r_sin_meta <= i_sync_in;
      r_sin_sync <= r_sin_meta;
    end
  end

  assign w_s          = r_sin_sync;
  assign w_frame_edge = w_s & ~r_s_prev;
  assign w_exp_n1     = CW1'(r_exp_n) + C1;
  assign w_exp_m1     = CW1'(r_exp_m) + C1;
  assign w_exp_m2     = CW1'(r_exp_m) + C2;
  assign w_hi_inc     = (r_hi  == '1) ? r_hi  : r_hi  + C1;
  assign w_per_inc    = (r_per == '1) ? r_per : r_per + C1;
  assign w_err_inc    = (r_err == '1) ? r_err : r_err + E1;

  // State register and all per-frame measurement state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= UNLOCKED;
      r_good   <= '0;
      r_miss   <= '0;
      r_hi     <= '0;
      r_per    <= '0;
      r_phase  <= '0;
      r_exp_n  <= '0;
      r_exp_m  <= '0;
      r_err    <= '0;
      r_s_prev <= 1'b0;
      r_fs     <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_good   <= w_good_nx;
      r_miss   <= w_miss_nx;
      r_hi     <= w_hi_nx;
      r_per    <= w_per_nx;
      r_phase  <= w_phase_nx;
      r_exp_n  <= w_exp_n_nx;
      r_exp_m  <= w_exp_m_nx;
      r_err    <= w_err_nx;
      r_s_prev <= w_s_prev_nx;
      r_fs     <= w_fs_nx;
    end
  end

  // Next-state logic: tick sampling, frame measurement, evaluation and lock control.
  always_comb begin
    w_state_nx   = r_state;
    w_good_nx    = r_good;
    w_miss_nx    = r_miss;
    w_hi_nx      = r_hi;
    w_per_nx     = r_per;
    w_phase_nx   = r_phase;
    w_exp_n_nx   = r_exp_n;
    w_exp_m_nx   = r_exp_m;
    w_err_nx     = r_err;
    w_s_prev_nx  = r_s_prev;
    w_fs_nx      = 1'b0;
    w_eval       = 1'b0;
    w_good_frame = 1'b0;

    if (!i_en) begin
      w_state_nx  = UNLOCKED;
      w_good_nx   = '0;
      w_miss_nx   = '0;
      w_hi_nx     = '0;
      w_per_nx    = '0;
      w_phase_nx  = '0;
      w_s_prev_nx = 1'b0;
    end else if (w_tick) begin
      w_s_prev_nx = w_s;
      if (w_frame_edge) begin
        w_fs_nx    = 1'b1;
        w_exp_n_nx = i_cnt_n;
        w_exp_m_nx = i_cnt_m;
        w_hi_nx    = C1;
        w_per_nx   = C1;
        w_phase_nx = '0;
        if (r_state == UNLOCKED) begin
          w_state_nx = ACQUIRE;
          w_good_nx  = '0;
          w_miss_nx  = '0;
        end else if (r_per != '0) begin
          w_eval       = 1'b1;
          w_good_frame = (r_hi == w_exp_n1) && (r_per == w_exp_m1);
        end
      end else if (r_state != UNLOCKED) begin
        w_hi_nx    = w_s ? w_hi_inc : r_hi;
        w_per_nx   = w_per_inc;
        w_phase_nx = (r_phase == r_exp_m) ? '0 : r_phase + P1;
        if (w_per_inc == w_exp_m2) begin
          w_eval   = 1'b1;
          w_hi_nx  = '0;
          w_per_nx = '0;
        end
      end

      if (w_eval) begin
        if (r_state == ACQUIRE) begin
          if (w_good_frame) begin
            w_good_nx = r_good + G1;
            if (w_good_nx == 4'(LOCK_FRAMES)) begin
              w_state_nx = LOCKED;
              w_miss_nx  = '0;
            end
          end else begin
            w_good_nx = '0;
            w_err_nx  = w_err_inc;
          end
        end else if (r_state == LOCKED) begin
          if (w_good_frame) begin
            w_miss_nx = '0;
          end else begin
            w_miss_nx = r_miss + G1;
            w_err_nx  = w_err_inc;
            if (w_miss_nx == 4'(MISS_LIMIT)) begin
              w_state_nx = UNLOCKED;
              w_miss_nx  = '0;
              w_good_nx  = '0;
              w_hi_nx    = '0;
              w_per_nx   = '0;
              w_phase_nx = '0;
            end
          end
        end
      end
    end
  end

  assign o_locked      = (r_state == LOCKED);
  assign o_frame_start = r_fs;
  assign o_phase       = r_phase;
  assign o_err_cnt     = r_err;

endmodule

// File: tb/tb_sync_pattern_receiver.sv
// Directed bench for sync_pattern_receiver (CNT_W=2, LOCK_FRAMES=4,
// MISS_LIMIT=2, ERR_W=8). Every expected value below is hand-derived.
module tb_sync_pattern_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       toggle_en;
  logic       sync_in;
  logic [1:0] cnt_n;
  logic [1:0] cnt_m;
  logic       locked;
  logic       frame_start;
  logic [1:0] phase;
  logic [7:0] err_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int fs_cnt   = 0;
  int fs_lat   = 0;
  int fs_sum   = 0;

  always #5 clk = ~clk;

  sync_pattern_receiver #(
    .CNT_W       (2),
    .LOCK_FRAMES (4),
    .MISS_LIMIT  (2),
    .ERR_W       (8)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_en          (en),
    .i_toggle_en   (toggle_en),
    .i_sync_in     (sync_in),
    .i_cnt_n       (cnt_n),
    .i_cnt_m       (cnt_m),
    .o_locked      (locked),
    .o_frame_start (frame_start),
    .o_phase       (phase),
    .o_err_cnt     (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One master tick: set the line, raise toggle_en at a random clk phase,
  // lower it after 5 clk, and watch 9 clk for frame_start pulses.
  task automatic do_tick(input logic s);
    int d;
    @(negedge clk);
    d = $urandom_range(0, 4);
    #(d);
    sync_in   = s;
    toggle_en = 1'b1;
    fs_cnt    = 0;
    fs_lat    = 0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      if (frame_start === 1'b1) begin
        fs_cnt++;
        fs_lat = k;
      end
      if (k == 5) toggle_en = 1'b0;
    end
    fs_sum += fs_cnt;
  endtask

  task automatic finish_frame();
    do_tick(1'b1);
    do_tick(1'b0);
    do_tick(1'b0);
  endtask

  // Ideal n=1/m=3 master frames: high, high, low, low.
  task automatic master_frames(input int nf, input string tag);
    for (int f = 0; f < nf; f++) begin
      do_tick(1'b1);
      chk({tag, "_fs_pulse"}, fs_cnt, 1);
      chk({tag, "_fs_latency"}, fs_lat, 4);
      do_tick(1'b1);
      chk({tag, "_no_fs"}, fs_cnt, 0);
      do_tick(1'b0);
      do_tick(1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; toggle_en = 1'b0; sync_in = 1'b0;
    cnt_n = 2'd1; cnt_m = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_phase", phase, 0);
    chk("rst_err", err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    repeat (2) @(posedge clk);

    // Acquisition: lock on the 5th frame start.
    master_frames(4, "acq");
    chk("acq_not_yet_locked", locked, 0);
    do_tick(1'b1);
    chk("acq_locked", locked, 1);
    chk("acq_phase0", phase, 0);
    chk("acq_lock_fs", fs_cnt, 1);
    do_tick(1'b1);
    chk("acq_phase1", phase, 1);
    do_tick(1'b0);
    chk("acq_phase2", phase, 2);
    do_tick(1'b0);
    chk("acq_phase3", phase, 3);
    chk("acq_err", err_cnt, 0);

    // Glitch mid-high: extra frame start, then two bad frames unlock.
    do_tick(1'b1);
    chk("gl_good_fs", fs_cnt, 1);
    do_tick(1'b0);
    do_tick(1'b1);
    chk("gl_extra_fs", fs_cnt, 1);
    chk("gl_err1", err_cnt, 1);
    chk("gl_still_locked", locked, 1);
    do_tick(1'b0);
    do_tick(1'b0);
    do_tick(1'b1);
    chk("gl_unlocked", locked, 0);
    chk("gl_err2", err_cnt, 2);

    // Re-acquire.
    finish_frame();
    master_frames(4, "reacq");
    do_tick(1'b1);
    chk("reacq_locked", locked, 1);
    chk("reacq_err", err_cnt, 2);

    // One bad frame then a good one: lock kept, miss cleared.
    do_tick(1'b1);
    do_tick(1'b1);
    do_tick(1'b0);
    do_tick(1'b1);
    chk("bg_bad1_err", err_cnt, 3);
    chk("bg_bad1_locked", locked, 1);
    finish_frame();
    do_tick(1'b1);
    chk("bg_good_locked", locked, 1);
    chk("bg_good_err", err_cnt, 3);
    do_tick(1'b1);
    do_tick(1'b1);
    do_tick(1'b0);
    do_tick(1'b1);
    chk("bg_bad2_err", err_cnt, 4);
    chk("bg_bad2_locked_miss_cleared", locked, 1);
    finish_frame();
    do_tick(1'b1);
    chk("bg_good2_locked", locked, 1);

    // Line stuck low: timeout on the 5th tick of a frame, twice -> unlock.
    fs_sum = 0;
    for (int i = 0; i < 3; i++) do_tick(1'b0);
    chk("sl_before_to_err", err_cnt, 4);
    do_tick(1'b0);
    chk("sl_to1_err", err_cnt, 5);
    chk("sl_to1_locked", locked, 1);
    for (int i = 0; i < 4; i++) do_tick(1'b0);
    chk("sl_between_err", err_cnt, 5);
    chk("sl_between_locked", locked, 1);
    do_tick(1'b0);
    chk("sl_to2_err", err_cnt, 6);
    chk("sl_to2_unlocked", locked, 0);
    chk("sl_no_frame_start", fs_sum, 0);

    // Disable mid-frame.
    master_frames(4, "dis_acq");
    do_tick(1'b1);
    chk("dis_locked_before", locked, 1);
    do_tick(1'b1);
    chk("dis_phase_before", phase, 1);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("dis_locked", locked, 0);
    chk("dis_phase", phase, 0);
    chk("dis_err_kept", err_cnt, 6);
    @(negedge clk);
    en = 1'b1;

    // Asynchronous reset between clk edges.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_err", err_cnt, 0);
    chk("arst_phase", phase, 0);
    chk("arst_frame_start", frame_start, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    sync_in = 1'b0;
    cnt_m   = 2'd2;
    repeat (3) @(posedge clk);

    // Configuration mismatch: one bad frame per master frame, saturating.
    master_frames(3, "mm");
    chk("mm_err3", err_cnt, 3);
    chk("mm_unlocked", locked, 0);
    master_frames(251, "mm");
    chk("mm_err254", err_cnt, 254);
    master_frames(1, "mm");
    chk("mm_err255", err_cnt, 255);
    master_frames(2, "mm");
    chk("mm_err_saturated", err_cnt, 255);
    chk("mm_never_locked", locked, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
